mem_access_responder: RTL

Memory-side responder for core load/store requests. Runs in the system clock domain, after the request signals have passed through the two-flop synchronizers. Turns each 4-phase level request (load or store) into one access on a single-ported memory load/store port, waits for the memory valid, and returns an acknowledge (plus load data) held stable until the request drops, so the result can safely re-cross into the core clock domain.

---
 rtl/mem_access_pkg.sv | 19 +
 rtl/mem_access_responder_wait_timer.sv | 27 ++
 rtl/mem_access_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and default widths for the memory access responder and the
// synchronizer instances that feed it.
package mem_access_pkg;

    localparam int MEM_ADDR_WIDTH = 11;
    localparam int MEM_DATA_WIDTH = 32;
    localparam int TIMER_WIDTH    = 8;

    typedef enum logic [2:0] {
        IDLE,
        LD_CAP,
        LD_WAIT,
        LD_DONE,
        ST_CAP,
        ST_WAIT,
        ST_DONE
    } mem_access_state_t;

endpackage

// File: rtl/mem_access_responder_wait_timer.sv
// Wait-state timer: cleared by load, counts up while run is high, and flags
// expiry once the count reaches LIMIT-1 (then holds there).
module wait_timer #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 15
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             run,
    output logic             expired,
    output logic [WIDTH-1:0] count
);

    assign expired = (count == WIDTH'(LIMIT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mem_access_responder.sv
// Memory-side responder: converts 4-phase load/store request levels into one
// memory access each and returns a held acknowledge for safe re-crossing.
module mem_access_responder
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_adrs,
    input  logic                  st_req,
    input  logic [ADDR_WIDTH-1:0] st_adrs,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic                  ld_ack,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  st_ack,
    output logic                  mem_r_en,
    output logic [ADDR_WIDTH-1:0] mem_r_adrs,
    input  logic                  mem_r_valid,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_w_adrs,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic                  mem_w_valid,
    output logic                  err
);

    mem_access_state_t      state;
    logic                   tmr_load;
    logic                   tmr_run;
    logic                   tmr_expired;
    logic [TIMER_WIDTH-1:0] tmr_count;

    // One timer serves both wait states; it is cleared during the capture cycle.
    assign tmr_load = (state == LD_CAP) || (state == ST_CAP);
    assign tmr_run  = (state == LD_WAIT) || (state == ST_WAIT);

    wait_timer #(
        .WIDTH (TIMER_WIDTH),
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .resetn  (resetn),
        .load    (tmr_load),
        .run     (tmr_run),
        .expired (tmr_expired),
        .count   (tmr_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            ld_ack     <= 1'b0;
            ld_data    <= '0;
            st_ack     <= 1'b0;
            mem_r_en   <= 1'b0;
            mem_r_adrs <= '0;
            mem_w_en   <= 1'b0;
            mem_w_adrs <= '0;
            mem_w_data <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Store has priority; a pending load is picked up afterwards.
                    if (st_req)      state <= ST_CAP;
                    else if (ld_req) state <= LD_CAP;
                end
                LD_CAP: begin
                    mem_r_adrs <= ld_adrs;
                    mem_r_en   <= 1'b1;
                    state      <= LD_WAIT;
                end
                LD_WAIT: begin
                    if (mem_r_valid) begin
                        ld_data  <= mem_r_data;
                        mem_r_en <= 1'b0;
                        ld_ack   <= 1'b1;
                        state    <= LD_DONE;
                    end else if (tmr_expired) begin
                        ld_data  <= '0;
                        err      <= 1'b1;
                        mem_r_en <= 1'b0;
                        ld_ack   <= 1'b1;
                        state    <= LD_DONE;
                    end
                end
                LD_DONE: begin
                    if (!ld_req) begin
                        ld_ack <= 1'b0;
                        state  <= IDLE;
                    end
                end
                ST_CAP: begin
                    mem_w_adrs <= st_adrs;
                    mem_w_data <= st_data;
                    mem_w_en   <= 1'b1;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_w_valid || tmr_expired) begin
                        if (!mem_w_valid) err <= 1'b1;
                        mem_w_en <= 1'b0;
                        st_ack   <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!st_req) begin
                        st_ack <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
